// File: rtl/disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int LANE_DIG0 = 0;
  localparam int LANE_DIG1 = 1;
  localparam int LANE_DIG2 = 2;
  localparam int LANE_DIG3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic logic [7:0] frame_lane(input logic [31:0] frame, input int lane);
    return frame[lane*8 +: 8];
  endfunction

  // Arbitration from an unowned state: when both request, the non-last owner wins.
  function automatic logic pick_owner(input logic [1:0] req, input logic last_owner);
    if (req == 2'b11) begin
      return ~last_owner;
    end else begin
      return req[1];
    end
  endfunction

endpackage

// File: rtl/disp_share_arb_if.sv
// Requester/display bundle for disp_share_arb.
interface disp_share_arb_if;
  logic [1:0]  req;
  logic [31:0] frame0;
  logic [31:0] frame1;
  logic [1:0]  gnt;
  logic [7:0]  in3;
  logic [7:0]  in2;
  logic [7:0]  in1;
  logic [7:0]  in0;
  logic        busy;

  modport slave (
    input  req, frame0, frame1,
    output gnt, in3, in2, in1, in0, busy
  );

  modport master (
    output req, frame0, frame1,
    input  gnt, in3, in2, in1, in0, busy
  );
endinterface

// File: rtl/disp_hold_timer.sv
// Saturating up-counter; expired_o is high once the count reaches LIMIT-1.
module disp_hold_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/disp_share_arb.sv
// Two-requester round-robin owner of the 4-digit display with minimum hold time.
// Optional blanking gap between owners is enabled by DISP_ARB_BLANK_EN.
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int HOLD_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input logic           clk,
  input logic           reset,
  disp_share_arb_if.slave bus
);

  if ((HOLD_CYC < 2) || (BLANK_CYC < 1)) begin : g_bad_param
    $error("disp_share_arb: HOLD_CYC must be >= 2 and BLANK_CYC >= 1");
  end

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        switch_s;
  logic        hold_exp_s;
  logic        own_req_s, oth_req_s;
  logic [1:0]  gnt_q, gnt_d;
  logic [31:0] frame_q, frame_d;
  logic        busy_q, busy_d;

  disp_hold_timer #(.LIMIT(HOLD_CYC)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .clear_i  ((state_q != ST_OWN) || switch_s),
    .en_i     (state_q == ST_OWN),
    .expired_o(hold_exp_s)
  );

`ifdef DISP_ARB_BLANK_EN
  logic gap_exp_s;

  disp_hold_timer #(.LIMIT(BLANK_CYC)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q != ST_GAP),
    .en_i     (state_q == ST_GAP),
    .expired_o(gap_exp_s)
  );
`endif

  assign own_req_s = bus.req[owner_q];
  assign oth_req_s = bus.req[~owner_q];

  // Next-state, owner bookkeeping and next output values.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    switch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = ST_OWN;
          owner_d = pick_owner(bus.req, last_q);
          last_d  = pick_owner(bus.req, last_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if ((!own_req_s && oth_req_s) || (hold_exp_s && oth_req_s)) begin
`ifdef DISP_ARB_BLANK_EN
          state_d = ST_GAP;
          last_d  = owner_q;
`else
          owner_d  = ~owner_q;
          last_d   = ~owner_q;
          switch_s = 1'b1;
`endif
        end else if (!own_req_s) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else begin
          state_d = ST_OWN;
        end
      end
`ifdef DISP_ARB_BLANK_EN
      ST_GAP: begin
        if (!gap_exp_s) begin
          state_d = ST_GAP;
        end else if (bus.req != 2'b00) begin
          state_d = ST_OWN;
          owner_d = pick_owner(bus.req, last_q);
          last_d  = pick_owner(bus.req, last_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so grant and digits move on the same edge.
    if (state_d == ST_OWN) begin
      gnt_d   = owner_d ? 2'b10 : 2'b01;
      frame_d = owner_d ? bus.frame1 : bus.frame0;
    end else begin
      gnt_d   = 2'b00;
      frame_d = {4{SEG_BLANK}};
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      frame_q <= {4{SEG_BLANK}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.in3  = frame_lane(frame_q, LANE_DIG3);
  assign bus.in2  = frame_lane(frame_q, LANE_DIG2);
  assign bus.in1  = frame_lane(frame_q, LANE_DIG1);
  assign bus.in0  = frame_lane(frame_q, LANE_DIG0);
  assign bus.busy = busy_q;

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Two-requester arbiter that time-shares the 4-digit seven-segment display between independent frame sources. Each requester presents a full 32-bit frame (four 8-bit segment patterns) and a request. The arbiter grants ownership with a minimum hold time, switches owners round-robin, and drives the registered `in3..in0` digit inputs of `disp_mux`. When no one owns the display, the digits are blank.

## Interface
- `HOLD_CYC`, 1000: minimum ownership time in clk cycles before the owner can be displaced; must be ≥2.
- `BLANK_CYC`, 16: length of the blanking gap between owners, in clk cycles (used only with `DISP_ARB_BLANK_EN`); must be ≥1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `req` in 2: request per requester; `req[i]` is level-sensitive.
- `frame0` in 32: requester 0 frame; `[31:24]`→digit 3 … `[7:0]`→digit 0.
- `frame1` in 32: requester 1 frame, same packing.
- `gnt` in 2 (output): one-hot grant, or `00`.
- `in3`, `in2`, `in1`, `in0` out 8 each: registered segment patterns to `disp_mux`; active-low, so `8'hFF` = blank.
- `busy` out 1: high while any grant is active or a blank gap is running.

## Operation
- States:
  - IDLE: `gnt=00`, digits `8'hFF`.
  - OWN: one grant active, hold counter running.
  - GAP: blanking, only with the macro.
- IDLE exit:
  - One request high → grant it.
  - Both high → grant the requester that is not `last_owner`.
  - `last_owner` resets to 1, so requester 0 wins first.
- OWN:
  - Digits track the owner's frame live, registered, so the owner may update content while it holds the display.
  - Counter starts at 0 on grant entry and saturates at `HOLD_CYC-1`; "expired" = counter at `HOLD_CYC-1`.
- OWN exits, checked in this order:
  1. Owner drops `req` (at any time, expired or not) → release. If the other requester is high, switch; else go to IDLE.
  2. Expired and other `req` high → switch to the other requester.
  3. Otherwise stay. Before expiry the owner cannot be pre-empted.
- Switch without the macro: go directly OWN→OWN(other). `gnt` flips one-hot in a single edge, counter restarts at 0, and `last_owner` updates to the new owner.
- Release to IDLE sets `last_owner` to the releasing owner.
- `gnt` is never `11`. A request arriving during GAP is sampled at GAP exit.

## Timing
- Reset values:
  - `gnt=00`, `busy=0`.
  - `in3..in0=8'hFF`.
  - state IDLE, counter 0, `last_owner=1`.
- Grant latency: `req` seen high at edge N (state IDLE) → `gnt` and the owner's frame on `in*` both valid after edge N+1. They always change on the same edge.
- Frame tracking latency in OWN: 1 cycle, frame input → `in*`.
- Release latency: `req` of owner low at edge N → `gnt=00` and digits `8'hFF` after edge N+1 (no other requester).
- Owner tenure with a waiting competitor: exactly `HOLD_CYC` cycles of `gnt` high.
- Reset mid-operation: return to reset values at the next edge. No frame content is retained.

## Configuration
- `DISP_ARB_BLANK_EN` defined:
  - Every owner switch passes through GAP for exactly `BLANK_CYC` cycles, with `gnt=00`, digits `8'hFF` and `busy=1`.
  - Then grant arbitration as in IDLE, using the updated `last_owner`.
  - Release to IDLE does not use GAP.
- Not defined: GAP state and `BLANK_CYC` logic are absent, and switches are direct.

## Structure
- Shared package `disp_pkg` holds:
  - `SEG_BLANK = 8'hFF`
  - state enum (IDLE/OWN/GAP)
  - frame byte-lane index constants.
- Sub-module `disp_hold_timer`: a parameterised saturating up-counter with `clear`, `en` and `expired` outputs. The arbiter instantiates it for the hold count, and for the gap count when the macro is on.
- Counter widths come from `$clog2` of the respective parameters.

## Test plan
Bench parameters: `HOLD_CYC=8`, `BLANK_CYC=4`, and a `disp_mux` instance for visual check.

1. **Reset.** Hold reset 3 cycles → `gnt=00`, `in3..in0=FF`, `busy=0`.
2. **Single requester.** `req=01`, `frame0=32'hC0F9A4B0` → next cycle `gnt=01`, `in3=C0`, `in2=F9`, `in1=A4`, `in0=B0`. Change `frame0[7:0]` to `99` → `in0=99` one cycle later.
3. **Contention with hold.** `req=11` from IDLE → `gnt=01` for exactly 8 cycles, then `gnt=10` with `frame1` shown. Keep both high → `gnt` alternates every 8 cycles.
4. **Early release.** Owner 0 drops `req` at cycle 3 of tenure with `req[1]` high → `gnt=10` next edge, hold not awaited. Owner 1 drops with no competitor → `gnt=00`, `in*=FF`.
5. **Blank gap** (`DISP_ARB_BLANK_EN` defined). Repeat scenario 3 → between tenures, exactly 4 cycles of `gnt=00`, `in*=FF`, `busy=1`.
6. **Reset mid-tenure.** Assert reset at counter=5 → all outputs at reset values next edge. After release of reset with `req=11`, requester 0 is granted first.
